ex_mem_branch_stage: RTL and testbench

//  EX/MEM pipeline register directly downstream of the N-bit ALU. Captures the ALU result and the cf/zf/vf/sf flags each

---
 rtl/ex_mem_branch_stage.sv | 104 ++++++++++
 tb/tb_ex_mem_branch_stage.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/ex_mem_branch_stage.sv
// ex_mem_branch_stage: EX/MEM register with branch resolution, one-shot redirect/flush, wrong-path squash and branch counters
module ex_mem_branch_stage #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ex_valid,
  input  logic [XLEN-1:0]  ex_alu_r,
  input  logic             ex_cf,
  input  logic             ex_zf,
  input  logic             ex_vf,
  input  logic             ex_sf,
  input  logic             ex_branch,
  input  logic             ex_jump,
  input  logic [2:0]       ex_funct3,
  input  logic [XLEN-1:0]  ex_target,
  input  logic [XLEN-1:0]  ex_pc_plus4,
  input  logic [XLEN-1:0]  ex_rs2_data,
  input  logic [4:0]       ex_rd,
  input  logic             ex_reg_write,
  input  logic             ex_mem_read,
  input  logic             ex_mem_write,
  input  logic             stall,
  output logic             mem_valid,
  output logic [XLEN-1:0]  mem_alu_r,
  output logic [XLEN-1:0]  mem_store_data,
  output logic [4:0]       mem_rd,
  output logic [2:0]       mem_funct3,
  output logic             mem_reg_write,
  output logic             mem_mem_read,
  output logic             mem_mem_write,
  output logic             redirect,
  output logic [XLEN-1:0]  redirect_pc,
  output logic             flush,
  output logic [CNT_W-1:0] br_taken_cnt,
  output logic [CNT_W-1:0] br_ntaken_cnt
);
  logic             valid_q, rw_q, mr_q, mw_q, taken_q, fired_q, fired_d;
  logic [XLEN-1:0]  alu_q, sd_q, tgt_q;
  logic [4:0]       rd_q;
  logic [2:0]       f3_q;
  logic [CNT_W-1:0] tcnt_q, ncnt_q;
  logic             cond, taken, live;
  always_comb begin
    cond = ex_funct3 == 3'b000 ? ex_zf :
           ex_funct3 == 3'b001 ? ~ex_zf :
           ex_funct3 == 3'b100 ? ex_sf ^ ex_vf :
           ex_funct3 == 3'b101 ? ~(ex_sf ^ ex_vf) :
           ex_funct3 == 3'b110 ? ~ex_cf :
           ex_funct3 == 3'b111 ? ex_cf : 1'b0;
    taken = ex_jump | (ex_branch & cond);
    redirect = valid_q & taken_q & ~fired_q;
    flush = redirect;
    // the instruction sitting in EX while we redirect is wrong-path
    live = ex_valid & ~redirect;
    // fired survives a stall so a held branch pulses once, and clears when MEM reloads
    fired_d = stall ? (fired_q | redirect) : 1'b0;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      alu_q   <= '0;
      sd_q    <= '0;
      tgt_q   <= '0;
      rd_q    <= '0;
      f3_q    <= '0;
      rw_q    <= 1'b0;
      mr_q    <= 1'b0;
      mw_q    <= 1'b0;
      taken_q <= 1'b0;
      fired_q <= 1'b0;
      tcnt_q  <= '0;
      ncnt_q  <= '0;
    end else begin
      fired_q <= fired_d;
      if (!stall) begin
        valid_q <= live;
        alu_q   <= ex_jump ? ex_pc_plus4 : ex_alu_r;
        sd_q    <= ex_rs2_data;
        tgt_q   <= ex_target;
        rd_q    <= ex_rd;
        f3_q    <= ex_funct3;
        rw_q    <= live & ex_reg_write;
        mr_q    <= live & ex_mem_read;
        mw_q    <= live & ex_mem_write;
        taken_q <= taken;
        if (live & ex_branch & taken) tcnt_q <= tcnt_q + 1'b1;
        if (live & ex_branch & ~taken) ncnt_q <= ncnt_q + 1'b1;
      end
    end
  end
  assign mem_valid      = valid_q;
  assign mem_alu_r      = alu_q;
  assign mem_store_data = sd_q;
  assign mem_rd         = rd_q;
  assign mem_funct3     = f3_q;
  assign mem_reg_write  = rw_q;
  assign mem_mem_read   = mr_q;
  assign mem_mem_write  = mw_q;
  assign redirect_pc    = tgt_q;
  assign br_taken_cnt   = tcnt_q;
  assign br_ntaken_cnt  = ncnt_q;
endmodule

// File: tb/tb_ex_mem_branch_stage.sv
// tb_ex_mem_branch_stage: directed + random stimulus against a comparison-level reference model
module tb_ex_mem_branch_stage;
  localparam int XLEN = 32;
  localparam int CW = 5;
  logic clk = 0, rst = 1;
  logic ex_valid, ex_cf, ex_zf, ex_vf, ex_sf, ex_branch, ex_jump;
  logic ex_reg_write, ex_mem_read, ex_mem_write, stall;
  logic [XLEN-1:0] ex_alu_r, ex_target, ex_pc_plus4, ex_rs2_data;
  logic [2:0] ex_funct3;
  logic [4:0] ex_rd;
  logic mem_valid, mem_reg_write, mem_mem_read, mem_mem_write, redirect, flush;
  logic [XLEN-1:0] mem_alu_r, mem_store_data, redirect_pc;
  logic [4:0] mem_rd;
  logic [2:0] mem_funct3;
  logic [CW-1:0] br_taken_cnt, br_ntaken_cnt;
  ex_mem_branch_stage #(.XLEN(XLEN), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .ex_valid(ex_valid), .ex_alu_r(ex_alu_r),
    .ex_cf(ex_cf), .ex_zf(ex_zf), .ex_vf(ex_vf), .ex_sf(ex_sf),
    .ex_branch(ex_branch), .ex_jump(ex_jump), .ex_funct3(ex_funct3),
    .ex_target(ex_target), .ex_pc_plus4(ex_pc_plus4), .ex_rs2_data(ex_rs2_data),
    .ex_rd(ex_rd), .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read),
    .ex_mem_write(ex_mem_write), .stall(stall), .mem_valid(mem_valid),
    .mem_alu_r(mem_alu_r), .mem_store_data(mem_store_data), .mem_rd(mem_rd),
    .mem_funct3(mem_funct3), .mem_reg_write(mem_reg_write), .mem_mem_read(mem_mem_read),
    .mem_mem_write(mem_mem_write), .redirect(redirect), .redirect_pc(redirect_pc),
    .flush(flush), .br_taken_cnt(br_taken_cnt), .br_ntaken_cnt(br_ntaken_cnt)
  );
  always #5 clk = ~clk;
  int total = 0, bad = 0;
  logic [31:0] ea, eb;
  // reference: what MEM should hold, plus whether its redirect was already issued
  logic m_v, m_tk, m_fd, m_rw, m_mr, m_mw;
  logic [31:0] m_alu, m_sd, m_pc;
  logic [4:0] m_rd;
  logic [2:0] m_f3;
  int unsigned c_t, c_n;
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask
  function automatic logic br_cond(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    case (f)
      3'd0: return a == b;
      3'd1: return a != b;
      3'd4: return $signed(a) < $signed(b);
      3'd5: return $signed(a) >= $signed(b);
      3'd6: return a < b;
      3'd7: return a >= b;
      default: return 1'b0;
    endcase
  endfunction
  task automatic model_clear();
    {m_v, m_tk, m_fd, m_rw, m_mr, m_mw} = '0;
    m_alu = 0; m_sd = 0; m_pc = 0; m_rd = 0; m_f3 = 0; c_t = 0; c_n = 0;
  endtask
  task automatic check_all();
    logic er;
    er = m_v & m_tk & ~m_fd;
    chk("mem_valid", mem_valid, m_v);
    chk("mem_alu_r", mem_alu_r, m_alu);
    chk("mem_store_data", mem_store_data, m_sd);
    chk("mem_rd", mem_rd, m_rd);
    chk("mem_funct3", mem_funct3, m_f3);
    chk("mem_reg_write", mem_reg_write, m_rw);
    chk("mem_mem_read", mem_mem_read, m_mr);
    chk("mem_mem_write", mem_mem_write, m_mw);
    chk("redirect", redirect, er);
    chk("flush", flush, er);
    chk("redirect_pc", redirect_pc, m_pc);
    chk("br_taken_cnt", br_taken_cnt, c_t);
    chk("br_ntaken_cnt", br_ntaken_cnt, c_n);
  endtask
  task automatic op(input logic v, input logic br, input logic jmp, input logic [2:0] f3,
                    input logic [31:0] a, input logic [31:0] b, input logic [31:0] tgt, input logic st);
    logic [31:0] d;
    ea = a; eb = b; d = a - b;
    ex_valid = v; ex_branch = br; ex_jump = jmp; ex_funct3 = f3; ex_target = tgt; stall = st;
    ex_alu_r = d; ex_zf = (d == 0); ex_cf = (a >= b); ex_sf = d[31];
    ex_vf = (a[31] != b[31]) && (d[31] != a[31]);
    ex_pc_plus4 = $urandom; ex_rs2_data = $urandom; ex_rd = 5'($urandom);
    ex_reg_write = 1'($urandom); ex_mem_read = 1'($urandom); ex_mem_write = 1'($urandom);
  endtask
  task automatic cyc();
    logic red, tk, lv;
    red = m_v & m_tk & ~m_fd;
    tk = ex_jump | (ex_branch & br_cond(ex_funct3, ea, eb));
    @(posedge clk);
    if (rst) model_clear();
    else if (stall) m_fd = m_fd | red;
    else begin
      lv = ex_valid & ~red;
      m_v = lv; m_tk = tk; m_fd = 0;
      m_alu = ex_jump ? ex_pc_plus4 : ea - eb;
      m_sd = ex_rs2_data; m_pc = ex_target; m_rd = ex_rd; m_f3 = ex_funct3;
      m_rw = lv & ex_reg_write; m_mr = lv & ex_mem_read; m_mw = lv & ex_mem_write;
      if (lv & ex_branch) begin
        if (tk) c_t = (c_t + 1) % (1 << CW);
        else c_n = (c_n + 1) % (1 << CW);
      end
    end
    @(negedge clk);
    check_all();
  endtask
  initial begin
    model_clear();
    op(1, 1, 0, 3'd0, 5, 5, 32'h100, 1);
    cyc(); cyc();
    chk("rst_valid", mem_valid, 0);
    chk("rst_redirect", redirect, 0);
    rst = 0;
    // BEQ taken
    op(1, 1, 0, 3'd0, 5, 5, 32'h100, 0); cyc();
    chk("beq_redirect", redirect, 1);
    chk("beq_pc", redirect_pc, 32'h100);
    chk("beq_tcnt", br_taken_cnt, 1);
    op(0, 0, 0, 3'd2, 1, 2, 0, 0); cyc();
    chk("beq_one_shot", redirect, 0);
    // BLTU taken, BGE not taken
    op(1, 1, 0, 3'd6, 1, 2, 32'h200, 0); cyc();
    chk("bltu_redirect", redirect, 1);
    op(0, 0, 0, 3'd0, 0, 0, 0, 0); cyc();
    op(1, 1, 0, 3'd5, 32'hFFFF_FFFF, 1, 32'h300, 0); cyc();
    chk("bge_no_redirect", redirect, 0);
    chk("bge_ncnt", br_ntaken_cnt, 1);
    // taken BNE squashes the following ADD
    op(1, 1, 0, 3'd1, 3, 4, 32'h400, 0); cyc();
    op(1, 0, 0, 3'd0, 7, 1, 0, 0); ex_reg_write = 1; cyc();
    chk("squash_valid", mem_valid, 0);
    chk("squash_rw", mem_reg_write, 0);
    chk("squash_tcnt", br_taken_cnt, 3);
    // JAL held under stall: single pulse
    op(1, 0, 1, 3'd0, 0, 0, 32'h500, 0); ex_pc_plus4 = 32'h24; cyc();
    chk("jal_redirect", redirect, 1);
    for (int i = 0; i < 3; i++) begin
      op(1, 1, 0, 3'd0, 9, 9, 0, 1); cyc();
      chk("stall_no_repeat", redirect, 0);
      chk("stall_alu_hold", mem_alu_r, 32'h24);
    end
    // reset with a taken branch in MEM
    op(1, 1, 0, 3'd0, 1, 1, 32'h600, 0); cyc();
    chk("pre_rst_redirect", redirect, 1);
    rst = 1; op(1, 1, 0, 3'd0, 1, 1, 32'h700, 1); cyc();
    chk("post_rst_redirect", redirect, 0);
    chk("post_rst_tcnt", br_taken_cnt, 0);
    rst = 0;
    // ntaken counter wraps
    for (int i = 0; i < (1 << CW) - 1; i++) begin
      op(1, 1, 0, 3'd0, 1, 2, 0, 0); cyc();
    end
    chk("ncnt_max", br_ntaken_cnt, (1 << CW) - 1);
    op(1, 1, 0, 3'd0, 1, 2, 0, 0); cyc();
    chk("ncnt_wrap", br_ntaken_cnt, 0);
    // random traffic
    for (int i = 0; i < 800; i++) begin
      logic [31:0] a, b;
      logic br;
      a = $urandom; b = ($urandom_range(0, 3) == 0) ? a : $urandom;
      if ($urandom_range(0, 3) == 0) b = a + 32'($urandom_range(0, 2)) - 1;
      br = 1'($urandom);
      op(1'($urandom_range(0, 4) != 0), br, ~br & ($urandom_range(0, 5) == 0), 3'($urandom),
         a, b, $urandom, $urandom_range(0, 3) == 0);
      rst = $urandom_range(0, 60) == 0;
      cyc();
      rst = 0;
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
